// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory responder slice.
package mem_pkg;

  localparam int unsigned MAR_W       = 32;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DEF_WORD_W  = 32;
  localparam int unsigned DEF_ADDR_W  = 9;
  localparam int unsigned DEF_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_responder_if.sv
// Read/Write/MAR/MDR handshake between the control sequence and the memory responder.
interface mem_responder_if #(
  parameter int unsigned WORD_W = mem_pkg::DEF_WORD_W
);
  logic                     Read;
  logic                     Write;
  logic [mem_pkg::MAR_W-1:0] address;
  logic [WORD_W-1:0]        data_in;
  logic [WORD_W-1:0]        Mdatain;
  logic                     Done;
  logic                     Busy;
  logic                     Err;

  modport master (
    output Read, Write, address, data_in,
    input  Mdatain, Done, Busy, Err
  );

  modport slave (
    input  Read, Write, address, data_in,
    output Mdatain, Done, Busy, Err
  );
endinterface

// File: rtl/mem_array.sv
// Synchronous single-port word RAM with a registered read port; contents are never reset.
module mem_array #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORD_W = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts a Read/Write strobe edge, waits a fixed latency,
// then pulses Done for one cycle with read data on Mdatain.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned WORD_W  = DEF_WORD_W
) (
  input logic             clock,
  input logic             clear,
  mem_responder_if.slave  bus
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WORD_W-1:0] mdat_q, mdat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdat_q, wdat_d;
  op_t               op_q, op_d;

  logic              req_c;
  logic              rise_c;
  logic [ADDR_W-1:0] live_addr_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [WORD_W-1:0] ram_wdata_c;
  logic [WORD_W-1:0] ram_rdata;
  logic              unused_addr_c;

  assign req_c         = bus.Read | bus.Write;
  assign rise_c        = req_c & ~req_q;
  assign live_addr_c   = bus.address[ADDR_W-1:0];
  assign unused_addr_c = ^bus.address[MAR_W-1:ADDR_W];

  // In IDLE the RAM reads the live address so a LATENCY=1 read has data ready on its RESP exit.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    op_d        = op_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    mdat_d      = mdat_q;
    ram_we_c    = 1'b0;
    ram_addr_c  = addr_q;
    ram_wdata_c = wdat_q;

    case (state_q)
      IDLE: begin
        ram_addr_c  = live_addr_c;
        ram_wdata_c = bus.data_in;
        if (rise_c) begin
          if (bus.Read && bus.Write) begin
            err_d = 1'b1;
          end else begin
            addr_d = live_addr_c;
            wdat_d = bus.data_in;
            op_d   = bus.Write ? OP_WR : OP_RD;
            cnt_d  = CNT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              state_d  = RESP;
              ram_we_c = bus.Write;
            end else begin
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d  = RESP;
          ram_we_c = (op_q == OP_WR);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Done and read data are registered out of RESP; Busy spans through the Done cycle.
    done_d = (state_q == RESP);
    busy_d = (state_d != IDLE) || (state_q == RESP);
    if ((state_q == RESP) && (op_q == OP_RD)) begin
      mdat_d = ram_rdata;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mdat_q  <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      op_q    <= OP_RD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_c;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mdat_q  <= mdat_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      op_q    <= op_d;
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem_array (
    .clock (clock),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  assign bus.Mdatain = mdat_q;
  assign bus.Done    = done_q;
  assign bus.Busy    = busy_q;
  assign bus.Err     = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a LATENCY=2 and a LATENCY=1 instance share one clock and clear.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEPTH  = 512;
  localparam int          NDUT   = 2;

  typedef struct {
    bit          is_rd;
    bit          known;
    logic [31:0] data;
    logic [8:0]  addr;
    int          e0;
  } exp_t;

  logic        clock = 1'b0;
  logic        clear;
  logic        rd     [NDUT];
  logic        wr     [NDUT];
  logic [31:0] adr    [NDUT];
  logic [31:0] din    [NDUT];
  logic [31:0] mdat_s [NDUT];
  logic        done_s [NDUT];
  logic        busy_s [NDUT];
  logic        err_s  [NDUT];

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          run = 1'b0;

  exp_t        sbq [NDUT][$];
  logic [31:0] mdl_mem   [NDUT][DEPTH];
  bit          mdl_known [NDUT][DEPTH];
  logic [31:0] mdl_mdat  [NDUT];
  bit          mdl_mdat_ok [NDUT];
  bit          mdl_err   [NDUT];
  int          last_e0   [NDUT];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit exp_busy(input int k);
    return (cyc >= last_e0[k]) && (cyc <= last_e0[k] + lat_of(k));
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d @cyc %0d: got %h, expected %h", nm, k, cyc, act, exp);
    end
  endtask

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    mem_responder_if #(.WORD_W(WORD_W)) u_if ();
    exp_t e;

    assign u_if.Read    = rd[k];
    assign u_if.Write   = wr[k];
    assign u_if.address = adr[k];
    assign u_if.data_in = din[k];
    assign mdat_s[k]    = u_if.Mdatain;
    assign done_s[k]    = u_if.Done;
    assign busy_s[k]    = u_if.Busy;
    assign err_s[k]     = u_if.Err;

    mem_responder #(
      .ADDR_W  (ADDR_W),
      .LATENCY ((k == 0) ? 2 : 1),
      .WORD_W  (WORD_W)
    ) u_dut (
      .clock (clock),
      .clear (clear),
      .bus   (u_if.slave)
    );

    // Monitor: pops the scoreboard on Done and checks Busy/Err/Mdatain every cycle.
    always @(negedge clock) begin
      if (run && !clear) begin
        chk("busy", k, 32'(busy_s[k]), 32'(exp_busy(k)));
        chk("err", k, 32'(err_s[k]), 32'(mdl_err[k]));
        if (done_s[k]) begin
          if (sbq[k].size() == 0) begin
            chk("done_unexpected", k, 32'(done_s[k]), 32'd0);
          end else begin
            e = sbq[k].pop_front();
            chk("done_latency", k, 32'(cyc), 32'(e.e0 + lat_of(k)));
            if (e.is_rd) begin
              mdl_mdat_ok[k] = e.known;
              mdl_mdat[k]    = e.data;
            end else begin
              mdl_mem[k][e.addr]   = e.data;
              mdl_known[k][e.addr] = 1'b1;
            end
          end
        end else if (sbq[k].size() != 0 && cyc > sbq[k][0].e0 + lat_of(k)) begin
          chk("done_missing", k, 32'(done_s[k]), 32'd1);
          e = sbq[k].pop_front();
        end
        if (mdl_mdat_ok[k]) chk("mdatain", k, mdat_s[k], mdl_mdat[k]);
      end
    end
  end

  task automatic wait_idle(input int k);
    int t = 0;
    @(negedge clock);
    while (cyc < last_e0[k] + lat_of(k) && t < 64) begin
      @(negedge clock);
      t++;
    end
    if (t >= 64) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_wait dut%0d: cycle %0d, still waiting for %0d", k, cyc, last_e0[k] + lat_of(k));
    end
  endtask

  // Called at a negedge with strobes low and the responder free to accept.
  task automatic issue(input int k, input bit do_rd, input bit do_wr, input logic [31:0] a,
                       input logic [31:0] d, input int hold, input bit poke);
    exp_t e;
    adr[k] = a;
    din[k] = d;
    rd[k]  = do_rd;
    wr[k]  = do_wr;
    @(posedge clock);
    #1;
    if (do_rd && do_wr) begin
      mdl_err[k] = 1'b1;
    end else if (do_rd || do_wr) begin
      e.is_rd = do_rd;
      e.addr  = a[8:0];
      e.e0    = cyc;
      e.known = do_rd ? mdl_known[k][a[8:0]] : 1'b1;
      e.data  = do_rd ? mdl_mem[k][a[8:0]] : d;
      sbq[k].push_back(e);
      last_e0[k] = cyc;
    end
    for (int i = 1; i < hold; i++) @(posedge clock);
    @(negedge clock);
    rd[k]  = 1'b0;
    wr[k]  = 1'b0;
    adr[k] = $urandom;
    din[k] = $urandom;
    if (poke) begin
      @(negedge clock);
      wr[k] = 1'b1;
      @(negedge clock);
      wr[k] = 1'b0;
    end
    wait_idle(k);
  endtask

  task automatic flush_models();
    for (int k = 0; k < NDUT; k++) begin
      sbq[k].delete();
      mdl_err[k]     = 1'b0;
      mdl_mdat[k]    = 32'h0;
      mdl_mdat_ok[k] = 1'b1;
      last_e0[k]     = -100;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int k;
    int hold;
    logic [31:0] a;

    clear = 1'b1;
    for (int j = 0; j < NDUT; j++) begin
      rd[j] = 1'b0; wr[j] = 1'b0; adr[j] = 32'h0; din[j] = 32'h0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mdl_mem[j][i]   = 32'h0;
        mdl_known[j][i] = 1'b0;
      end
    end
    flush_models();

    repeat (2) @(posedge clock);
    #2;
    for (int j = 0; j < NDUT; j++) begin
      chk("reset_mdatain", j, mdat_s[j], 32'h0);
      chk("reset_done", j, 32'(done_s[j]), 32'd0);
      chk("reset_busy", j, 32'(busy_s[j]), 32'd0);
      chk("reset_err", j, 32'(err_s[j]), 32'd0);
    end
    clear = 1'b0;
    run   = 1'b1;
    @(negedge clock);

    // Write then read, latency 2.
    issue(0, 1'b0, 1'b1, 32'h0000_0003, 32'h1234_5678, 1, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0003, 32'h0, 1, 1'b0);
    // Held read strobe gives a single access.
    issue(0, 1'b0, 1'b1, 32'h0000_0010, 32'h0BAD_F00D, 1, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 6, 1'b0);
    // Simultaneous strobes: Err, no access, memory unchanged.
    issue(0, 1'b1, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF, 1, 1'b0);
    issue(0, 1'b1, 1'b0, 32'h0000_0003, 32'h0, 1, 1'b0);
    // Address wrap plus a Write edge while busy.
    issue(0, 1'b0, 1'b1, 32'h0000_0205, 32'hA5A5_A5A5, 1, 1'b1);
    issue(0, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 1, 1'b0);

    // Abort a pending write with clear.
    issue(0, 1'b0, 1'b1, 32'h0000_0005, 32'h0, 1, 1'b0);
    adr[0] = 32'h0000_0005;
    din[0] = 32'hDEAD_BEEF;
    wr[0]  = 1'b1;
    @(posedge clock);
    #1;
    last_e0[0] = cyc;
    @(negedge clock);
    wr[0] = 1'b0;
    #2;
    clear = 1'b1;
    #1;
    chk("clear_done", 0, 32'(done_s[0]), 32'd0);
    chk("clear_busy", 0, 32'(busy_s[0]), 32'd0);
    chk("clear_mdatain", 0, mdat_s[0], 32'h0);
    flush_models();
    @(posedge clock);
    #2;
    clear = 1'b0;
    @(negedge clock);
    issue(0, 1'b1, 1'b0, 32'h0000_0005, 32'h0, 1, 1'b0);

    // Latency 1: write, then back-to-back reads with a one-cycle strobe gap.
    issue(1, 1'b0, 1'b1, 32'h0000_0007, 32'hCAFE_F00D, 1, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h0000_0007, 32'h0, 1, 1'b0);
    issue(1, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_2222, 1, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 1, 1'b0);
    issue(1, 1'b1, 1'b0, 32'h0000_0007, 32'h0, 1, 1'b0);

    // Randomized traffic on both instances.
    for (int it = 0; it < 80; it++) begin
      k    = it % 2;
      r    = $urandom_range(0, 31);
      a    = $urandom & 32'hFFFF_FE0F;
      hold = $urandom_range(1, 4);
      if (r == 0)
        issue(k, 1'b1, 1'b1, a, $urandom, hold, 1'b0);
      else if (r < 16)
        issue(k, 1'b1, 1'b0, a, $urandom, hold, 1'b0);
      else
        issue(k, 1'b0, 1'b1, a, $urandom, hold, (k == 0) && (hold == 1) && r[0]);
    end

    repeat (6) @(negedge clock);
    for (int j = 0; j < NDUT; j++) chk("pending_at_end", j, 32'(sbq[j].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
